fb_write_arbiter: RTL and testbench

- Owns the single write port of the framebuffer BlockRAM and shares it between two write requesters: requester 0 is the pattern generator and requester 1 is the Mandelbrot pixel engine.
- Contains a clear sequencer that sweeps the whole framebuffer with one colour on command.
- Sits between the pixel producers and the BlockRAM port A; the VGA read side on port B is untouched.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_rr_arbiter2.sv | 67 ++++++
 rtl/fb_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer write-side shared definitions: geometry, arbiter states, pixel type.
package fb_pkg;

  localparam int FB_COLUMNS    = 320;
  localparam int FB_LINES      = 240;
  localparam int FB_DEPTH      = FB_COLUMNS * FB_LINES;
  localparam int FB_ADDR_WIDTH = 17;
  localparam int FB_DATA_WIDTH = 12;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_arb_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } fb_pixel_t;

endpackage

// File: rtl/fb_rr_arbiter2.sv
// Two-requester grant logic for the framebuffer write port.
// FB_WRITE_ARB_ROUND_ROBIN_EN selects round robin (pointer holds the last
// granted requester); without it req0 always wins and no pointer exists.
// Grants are only raised for a valid requester, so a grant is a transfer.
module fb_rr_arbiter2 (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_grant0,
  output logic o_grant1
);

`ifdef FB_WRITE_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // On contention grant the requester that was not granted last.
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_en) begin
      if (i_valid0 && i_valid1) begin
        o_grant0 = ptr_q;
        o_grant1 = ~ptr_q;
      end else begin
        o_grant0 = i_valid0;
        o_grant1 = i_valid1;
      end
    end
  end

  // Pointer follows the requester that actually transferred.
  always_comb begin
    ptr_d = ptr_q;
    if (o_grant0) begin
      ptr_d = 1'b0;
    end else if (o_grant1) begin
      ptr_d = 1'b1;
    end
  end

  // Pointer register; resets to 1 so req0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ i_rst_n;

  // Fixed priority: req0 first, req1 only when req0 is idle.
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_en) begin
      o_grant0 = i_valid0;
      o_grant1 = ~i_valid0 & i_valid1;
    end
  end
`endif

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer BlockRAM port-A owner: arbitrates two pixel writers and runs a
// full-screen clear sweep. Optional macro FB_WRITE_ARB_ROUND_ROBIN_EN turns
// the fixed-priority grant into two-way round robin.
//
//   state | meaning
//   ARB   | serve requester writes, accept clear command
//   CLEAR | sweep 0..DEPTH-1 with the latched colour, requesters stalled
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int DEPTH      = FB_DEPTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_clear_color,
  output logic                  o_clear_busy,
  output logic                  o_clear_done,
  input  logic                  i_req0_valid,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_req1_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  output logic                  o_addr_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);

  fb_arb_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  grant0, grant1;
  logic                  acc_valid;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_in_range;

  fb_rr_arbiter2 u_arb (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_en     (state_q == ARB),
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .o_grant0 (grant0),
    .o_grant1 (grant1)
  );

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  assign acc_valid    = grant0 | grant1;
  assign acc_addr     = grant0 ? i_req0_addr : i_req1_addr;
  assign acc_data     = grant0 ? i_req0_data : i_req1_data;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_EXT);

  // Next-state and next-write decode for both the arbiter and clear sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ARB: begin
        if (acc_valid) begin
          if (acc_in_range) begin
            write_d = 1'b1;
            addr_d  = acc_addr;
            data_d  = acc_data;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_clear) begin
          state_d = CLEAR;
          color_d = i_clear_color;
        end
      end
      CLEAR: begin
        write_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = color_q;
        if (cnt_q == LAST_CNT) begin
          state_d = ARB;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and registered BlockRAM write port.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
      color_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_clear_busy = (state_q == CLEAR);
  assign o_clear_done = done_q;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_write      = write_q;
  assign o_addr_err   = err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a small DEPTH; expected port
// writes are queued one entry per cycle and compared a cycle later.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int D  = 16;
  localparam int AW = 17;
  localparam int DW = 12;
`ifdef FB_WRITE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [DW-1:0] color;
  logic          busy, done;
  logic          v0, v1, r0, r1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_write, o_addr_err;

  fb_write_arbiter #(.DEPTH(D), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_clear_color (color),
    .o_clear_busy  (busy),
    .o_clear_done  (done),
    .i_req0_valid  (v0),
    .i_req0_addr   (a0),
    .i_req0_data   (d0),
    .o_req0_ready  (r0),
    .i_req1_valid  (v1),
    .i_req1_addr   (a1),
    .i_req1_data   (d1),
    .o_req1_ready  (r1),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .o_write       (o_write),
    .o_addr_err    (o_addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic          done;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  fb_arb_state_t mstate = ARB;
  logic [AW-1:0] mcnt   = '0;
  logic [DW-1:0] mcolor = '0;
  logic          mptr   = 1'b1;
  logic          obs_r0, obs_r1;
  int            done_seen = 0;
  int            clr_writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare last cycle's expected write, check readies, then model this cycle.
  task automatic step_model();
    exp_t          e, n;
    logic          er0, er1;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("o_write", 32'(o_write), 32'(e.wr));
      chk("o_addr_err", 32'(o_addr_err), 32'(e.err));
      chk("o_clear_done", 32'(done), 32'(e.done));
      if (e.wr) begin
        chk("o_addr", 32'(o_addr), 32'(e.addr));
        chk("o_data", 32'(o_data), 32'(e.data));
      end
    end
    if (done === 1'b1) done_seen++;
    if (o_write === 1'b1 && o_data === 12'hF00) clr_writes++;

    er0 = 1'b0;
    er1 = 1'b0;
    if (mstate == ARB) begin
      if (RR && v0 && v1) begin
        er0 = mptr;
        er1 = ~mptr;
      end else begin
        er0 = v0;
        er1 = v1 & ~v0;
      end
    end
    chk("req0_ready", 32'(r0), 32'(er0));
    chk("req1_ready", 32'(r1), 32'(er1));
    chk("clear_busy", 32'(busy), 32'(mstate == CLEAR));
    obs_r0 = r0;
    obs_r1 = r1;

    n.wr = 1'b0; n.addr = '0; n.data = '0; n.err = 1'b0; n.done = 1'b0;
    if (!rst_n) begin
      mstate = ARB;
      mcnt   = '0;
      mptr   = 1'b1;
    end else if (mstate == ARB) begin
      if (er0 || er1) begin
        ta = er0 ? a0 : a1;
        td = er0 ? d0 : d1;
        if (ta < AW'(D)) begin
          n.wr = 1'b1; n.addr = ta; n.data = td;
        end else begin
          n.err = 1'b1;
        end
        mptr = er1;
      end
      if (clear) begin
        mstate = CLEAR;
        mcolor = color;
      end
    end else begin
      n.wr = 1'b1; n.addr = mcnt; n.data = mcolor;
      if (mcnt == AW'(D - 1)) begin
        n.done = 1'b1;
        mstate = ARB;
        mcnt   = '0;
      end else begin
        mcnt = mcnt + 1'b1;
      end
    end
    sb.push_back(n);
  endtask

  // One cycle: check at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g0, g1, guard;
    rst_n = 1'b0; clear = 1'b0; color = '0;
    v0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; a1 = '0; d1 = '0;
    repeat (3) cyc();
    chk("rst_o_write", 32'(o_write), 32'd0);
    chk("rst_o_addr", 32'(o_addr), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(o_addr_err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // single req0 write
    v0 = 1'b1; a0 = 17'd5; d0 = 12'hABC;
    cyc();
    chk("t1_ready0", 32'(obs_r0), 32'd1);
    v0 = 1'b0;
    chk("t1_o_addr", 32'(o_addr), 32'd5);
    chk("t1_o_data", 32'(o_data), 32'hABC);
    cyc();

    // contention for 4 cycles
    v0 = 1'b1; a0 = 17'd1; d0 = 12'h111;
    v1 = 1'b1; a1 = 17'd2; d1 = 12'h222;
    g0 = 0; g1 = 0;
    repeat (4) begin
      cyc();
      g0 += int'(obs_r0);
      g1 += int'(obs_r1);
    end
    chk("t2_grants0", 32'(g0), RR ? 32'd2 : 32'd4);
    chk("t2_grants1", 32'(g1), RR ? 32'd2 : 32'd0);
    v0 = 1'b0;
    cyc();
    v1 = 1'b0;
    cyc();

    // clear while req1 transfers, clear re-pulsed at count 7, req0 held waiting
    v1 = 1'b1; a1 = 17'd3; d1 = 12'h333;
    clear = 1'b1; color = 12'hF00;
    done_seen = 0; clr_writes = 0;
    cyc();
    chk("t3_ready1", 32'(obs_r1), 32'd1);
    v1 = 1'b0; clear = 1'b0; color = 12'h00F;
    v0 = 1'b1; a0 = 17'd7; d0 = 12'h777;
    guard = 0;
    while (mstate == CLEAR && guard < 40) begin
      clear = (mcnt == 17'd7);
      cyc();
      guard++;
    end
    clear = 1'b0;
    chk("t3_sweep_len", 32'(guard), 32'd16);
    cyc();
    v0 = 1'b0;
    cyc();
    cyc();
    chk("t3_done_count", 32'(done_seen), 32'd1);
    chk("t3_clear_writes", 32'(clr_writes), 32'd16);

    // reset in the middle of a clear
    clear = 1'b1; color = 12'h0F0;
    done_seen = 0;
    cyc();
    clear = 1'b0;
    guard = 0;
    while (!(mstate == CLEAR && mcnt == 17'd9) && guard < 40) begin
      cyc();
      guard++;
    end
    chk("t4_reached_cnt9", 32'(guard < 40), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t4_write_after_rst", 32'(o_write), 32'd0);
    chk("t4_busy_after_rst", 32'(busy), 32'd0);
    v0 = 1'b1; a0 = 17'd4; d0 = 12'h0DE;
    cyc();
    chk("t4_ready0", 32'(obs_r0), 32'd1);
    v0 = 1'b0;
    chk("t4_o_addr", 32'(o_addr), 32'd4);
    cyc();
    cyc();
    chk("t4_no_done", 32'(done_seen), 32'd0);

    // out-of-range address, then last legal address and far out of range
    v0 = 1'b1; a0 = 17'd16; d0 = 12'h123;
    cyc();
    chk("t5_ready0", 32'(obs_r0), 32'd1);
    v0 = 1'b0;
    chk("t5_err", 32'(o_addr_err), 32'd1);
    chk("t5_no_write", 32'(o_write), 32'd0);
    v1 = 1'b1; a1 = 17'd15; d1 = 12'h5A5;
    cyc();
    a1 = 17'h1FFFF; d1 = 12'h111;
    chk("t6_o_addr", 32'(o_addr), 32'd15);
    cyc();
    v1 = 1'b0;
    chk("t6_err", 32'(o_addr_err), 32'd1);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
